// File: rtl/motor_pulse_scheduler.sv
`timescale 1ns / 1ps
`default_nettype none
// ----------------------------------------------------------------------------
// motor_pulse_scheduler: servo frame timing, command arbitration and PWM output.
// Option MOTOR_REVERSE_GUARD_EN: one neutral frame on a 00<->10 direction flip.
// Revision 1.0
// ----------------------------------------------------------------------------
module motor_pulse_scheduler #(
  parameter int CLK_RATE        = 100000000,
  parameter int FRAME_HZ        = 50,
  parameter int NUM_STATES      = 24,
  parameter int MAX_PULSE       = 250000,
  parameter int TIMEOUT_FRAMES  = 25,
  parameter int OVR_HOLD_FRAMES = 50
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        NavReq,
  input  logic [4:0]  NavModInfo,
  output logic        NavAck,
  input  logic        OvrReq,
  input  logic [4:0]  OvrModInfo,
  output logic        OvrAck,
  output logic [4:0]  ModInfo,
  output logic [4:0]  State,
  input  logic [20:0] Pulse,
  output logic        PwmOut,
  output logic        FrameStart,
  output logic        Failsafe
);

  localparam int FRAME_TICKS = CLK_RATE / FRAME_HZ;
  localparam int CW = $clog2(FRAME_TICKS);
  localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
  localparam int HW = $clog2(OVR_HOLD_FRAMES + 1);
  localparam logic [4:0] NEUTRAL = 5'b00001;

  typedef enum logic [1:0] {NAV = 2'd0, OVERRIDE = 2'd1, FAILSAFE = 2'd2} fsm_e;

  fsm_e        fsm_q, fsm_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic [4:0]  state_idx_q, state_idx_d;
  logic [4:0]  mod_q, mod_d, pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [HW-1:0] hold_q, hold_d;
  logic        nav_ack_q, ovr_ack_q, frame_start_q, pwm_q, pwm_d;
  logic [20:0] pulse_lat_q, pulse_lat_d, pulse_clamp;

  logic       boundary, ovr_acc, nav_acc, acc_any, flip;
  logic [4:0] acc_raw, acc_data, cmd;

  assign boundary = (frame_cnt_q == CW'(FRAME_TICKS - 1));
  assign ovr_acc  = OvrReq && !ovr_ack_q;
  assign nav_acc  = NavReq && !nav_ack_q && !ovr_acc && (fsm_q != OVERRIDE);
  assign acc_any  = ovr_acc || nav_acc;
  assign acc_raw  = ovr_acc ? OvrModInfo : NavModInfo;
  assign acc_data = (acc_raw[1:0] == 2'b11) ? {acc_raw[4:2], 2'b01} : acc_raw;
  // An accept landing on the boundary cycle is applied directly, skipping pending.
  assign cmd      = acc_any ? acc_data : pend_q;

`ifdef MOTOR_REVERSE_GUARD_EN
  assign flip = ({mod_q[1:0], cmd[1:0]} == 4'b0010) || ({mod_q[1:0], cmd[1:0]} == 4'b1000);
`else
  assign flip = 1'b0;
`endif

  assign frame_cnt_d = boundary ? '0 : frame_cnt_q + 1'b1;
  assign state_idx_d = !boundary ? state_idx_q :
                       (state_idx_q == 5'(NUM_STATES - 1)) ? 5'd0 : state_idx_q + 1'b1;
  assign pulse_clamp = (Pulse > 21'(MAX_PULSE)) ? 21'(MAX_PULSE) : Pulse;
  assign pulse_lat_d = (frame_cnt_q == CW'(2)) ? pulse_clamp : pulse_lat_q;
  assign pwm_d = (32'(frame_cnt_d) >= 32'd3) && (32'(frame_cnt_d) < 32'd3 + 32'(pulse_lat_d));

  always_comb begin
    fsm_d      = fsm_q;
    hold_d     = hold_q;
    tmo_d      = tmo_q;
    mod_d      = mod_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (acc_any) begin
      pend_d     = acc_data;
      pend_vld_d = 1'b1;
    end
    if (ovr_acc) begin
      fsm_d  = OVERRIDE;
      hold_d = HW'(OVR_HOLD_FRAMES);
    end else if (nav_acc && fsm_q == FAILSAFE) begin
      fsm_d = NAV;
    end
    if (boundary) begin
      pend_vld_d = 1'b0;
      if (fsm_q == OVERRIDE && !ovr_acc) begin
        if (hold_q <= HW'(1)) begin
          fsm_d  = NAV;
          hold_d = '0;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      if (acc_any || pend_vld_q) begin
        tmo_d = '0;
        if (flip) begin
          // Park the command for one frame behind a neutral frame.
          mod_d      = NEUTRAL;
          pend_d     = cmd;
          pend_vld_d = 1'b1;
        end else begin
          mod_d = cmd;
        end
      end else if (fsm_q == FAILSAFE) begin
        mod_d = NEUTRAL;
        tmo_d = '0;
      end else if (32'(tmo_q) + 32'd1 >= 32'(TIMEOUT_FRAMES)) begin
        fsm_d  = FAILSAFE;
        mod_d  = NEUTRAL;
        tmo_d  = '0;
        hold_d = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fsm_q         <= FAILSAFE;
      frame_cnt_q   <= '0;
      state_idx_q   <= '0;
      mod_q         <= NEUTRAL;
      pend_q        <= '0;
      pend_vld_q    <= 1'b0;
      tmo_q         <= '0;
      hold_q        <= '0;
      nav_ack_q     <= 1'b0;
      ovr_ack_q     <= 1'b0;
      frame_start_q <= 1'b0;
      pulse_lat_q   <= '0;
      pwm_q         <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      frame_cnt_q   <= frame_cnt_d;
      state_idx_q   <= state_idx_d;
      mod_q         <= mod_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      tmo_q         <= tmo_d;
      hold_q        <= hold_d;
      nav_ack_q     <= nav_acc;
      ovr_ack_q     <= ovr_acc;
      frame_start_q <= boundary;
      pulse_lat_q   <= pulse_lat_d;
      pwm_q         <= pwm_d;
    end
  end

  assign NavAck     = nav_ack_q;
  assign OvrAck     = ovr_ack_q;
  assign ModInfo    = mod_q;
  assign State      = state_idx_q;
  assign PwmOut     = pwm_q;
  assign FrameStart = frame_start_q;
  assign Failsafe   = (fsm_q == FAILSAFE);

endmodule
`default_nettype wire

// File: tb/tb_motor_pulse_scheduler.sv
`timescale 1ns / 1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_motor_pulse_scheduler: directed vectors, queued expectations, output monitor.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_motor_pulse_scheduler;

  localparam int FT = 2000;
`ifdef MOTOR_REVERSE_GUARD_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        NavReq = 1'b0, OvrReq = 1'b0;
  logic [4:0]  NavModInfo = '0, OvrModInfo = '0;
  logic        NavAck, OvrAck, PwmOut, FrameStart, Failsafe;
  logic [4:0]  ModInfo, State;
  logic [20:0] Pulse = '0;

  always #5 CLK = ~CLK;

  // MAX_PULSE is shrunk so a clamped pulse still fits inside the 2000-clock frame.
  motor_pulse_scheduler #(
    .CLK_RATE(100000), .FRAME_HZ(50), .NUM_STATES(24),
    .MAX_PULSE(1000), .TIMEOUT_FRAMES(4), .OVR_HOLD_FRAMES(3)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .NavReq(NavReq), .NavModInfo(NavModInfo), .NavAck(NavAck),
    .OvrReq(OvrReq), .OvrModInfo(OvrModInfo), .OvrAck(OvrAck),
    .ModInfo(ModInfo), .State(State), .Pulse(Pulse),
    .PwmOut(PwmOut), .FrameStart(FrameStart), .Failsafe(Failsafe)
  );

  typedef struct packed { logic [4:0] st; logic [4:0] mod; logic fs; } frame_t;
  typedef struct packed { logic [1:0] kind; logic [31:0] f; logic [31:0] c; } ack_t;
  typedef struct packed { logic [31:0] f; logic [31:0] w; } pulse_t;

  frame_t fq[$];
  ack_t   aq[$];
  pulse_t pq[$];
  int vectors = 0;
  int errors  = 0;
  int tb_f = 0, tb_c = 0;
  logic mon_en = 1'b0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tb_f <= 0;
      tb_c <= 0;
    end else if (tb_c == FT - 1) begin
      tb_c <= 0;
      tb_f <= tb_f + 1;
    end else begin
      tb_c <= tb_c + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (frame %0d cnt %0d)", name, act, exp, tb_f, tb_c);
    end
  endtask

  // {Failsafe, ModInfo} seen at the start of frame f.
  function automatic logic [5:0] frame_exp(input int f);
    logic [5:0] r;
    if (f == 1)                  r = {1'b0, 5'b01000};
    else if (f == 2)             r = {1'b0, 5'b00001};
    else if (f <= 5)             r = {1'b0, 5'b00010};
    else if (f <= 9)             r = {1'b0, 5'b00101};
    else if (f == 10)            r = {1'b1, 5'b00001};
    else if (f == 11)            r = {1'b0, 5'b01100};
    else if (f == 12)            r = {1'b0, 5'b01101};
    else if (f == 13)            r = {1'b0, 5'b01000};
    else if (f == 14 && G == 1)  r = {1'b0, 5'b00001};
    else if (f <= 17 + G)        r = {1'b0, 5'b01010};
    else                         r = {1'b1, 5'b00001};
    return r;
  endfunction

  ack_t   a;
  frame_t fr;
  pulse_t p;
  logic   pwm_prev = 1'b0;
  int     rise_f = 0, rise_c = 0, hi_len = 0;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (NavAck || OvrAck) begin
        if (aq.size() == 0) check("ack_spurious", 32'({NavAck, OvrAck}), 32'd0);
        else begin
          a = aq.pop_front();
          check("ack_kind", 32'({NavAck, OvrAck}), 32'(a.kind));
          check("ack_frame", 32'(tb_f), a.f);
          check("ack_cnt", 32'(tb_c), a.c);
        end
      end
      if (FrameStart || (tb_c == 0 && tb_f > 0))
        check("frame_start", 32'(FrameStart), 32'(tb_c == 0 && tb_f > 0));
      if (FrameStart) begin
        if (fq.size() == 0) check("frame_spurious", 32'(FrameStart), 32'd0);
        else begin
          fr = fq.pop_front();
          check("state", 32'(State), 32'(fr.st));
          check("modinfo", 32'(ModInfo), 32'(fr.mod));
          check("failsafe", 32'(Failsafe), 32'(fr.fs));
        end
      end
      if (PwmOut && !pwm_prev) begin
        rise_f = tb_f;
        rise_c = tb_c;
        hi_len = 0;
      end
      if (PwmOut) hi_len++;
      if (!PwmOut && pwm_prev) begin
        if (pq.size() == 0) check("pulse_spurious", 32'(hi_len), 32'd0);
        else begin
          p = pq.pop_front();
          check("pulse_frame", 32'(rise_f), p.f);
          check("pulse_start", 32'(rise_c), 32'd3);
          check("pulse_width", 32'(hi_len), p.w);
        end
      end
      pwm_prev = PwmOut;
    end
  end

  task automatic wait_at(input int f, input int c);
    int n = 0;
    while (!(tb_f == f && tb_c == c) && n < 60000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 60000) begin
      vectors++;
      errors++;
      $display("FAIL wait_at: frame %0d cnt %0d never reached", f, c);
    end
  endtask

  task automatic wait_ack(input logic nav);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(nav ? NavAck : OvrAck) && n < 20000);
    if (n >= 20000) begin
      vectors++;
      errors++;
      $display("FAIL ack_timeout: no %s ack seen", nav ? "nav" : "ovr");
    end
  endtask

  task automatic nav_cmd(input int f, input int c, input logic [4:0] d, input int af, input int ac);
    wait_at(f, c);
    NavModInfo = d;
    NavReq     = 1'b1;
    aq.push_back({2'b10, 32'(af), 32'(ac)});
    wait_ack(1'b1);
    NavReq = 1'b0;
  endtask

  task automatic set_pulse(input int f, input int v, input int w);
    wait_at(f, 1);
    Pulse = 21'(v);
    if (w > 0) pq.push_back({32'(f), 32'(w)});
  endtask

  initial begin
    for (int f = 1; f <= 24; f++) begin
      logic [5:0] e;
      e = frame_exp(f);
      fq.push_back({5'(f % 24), e[4:0], e[5]});
    end
    #2 RST_N = 1'b0;
    #10;
    check("rst_modinfo", 32'(ModInfo), 32'h01);
    check("rst_state", 32'(State), 32'd0);
    check("rst_failsafe", 32'(Failsafe), 32'd1);
    check("rst_outs", 32'({PwmOut, NavAck, OvrAck, FrameStart}), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N  = 1'b1;
    mon_en = 1'b1;

    nav_cmd(0, 500, 5'b01000, 0, 501);
    set_pulse(1, 100, 100);
    nav_cmd(1, 200, 5'b00100, 1, 201);
    nav_cmd(1, 600, 5'b00011, 1, 601);
    set_pulse(2, 1200, 1000);

    // Same-cycle requests: override wins, nav stalls until the hold expires.
    wait_at(2, 500);
    NavModInfo = 5'b00101;
    NavReq     = 1'b1;
    OvrModInfo = 5'b00010;
    OvrReq     = 1'b1;
    aq.push_back({2'b01, 32'd2, 32'd501});
    aq.push_back({2'b10, 32'd5, 32'd1});
    wait_ack(1'b0);
    OvrReq = 1'b0;
    set_pulse(3, 1000, 1000);
    set_pulse(4, 0, 0);
    wait_ack(1'b1);
    NavReq = 1'b0;

    nav_cmd(10, 500, 5'b01100, 10, 501);
    nav_cmd(11, FT - 1, 5'b01101, 12, 0);
    nav_cmd(12, 500, 5'b01000, 12, 501);
    nav_cmd(13, 500, 5'b01010, 13, 501);

    set_pulse(24, 800, 0);
    wait_at(24, 100);
    check("pwm_before_reset", 32'(PwmOut), 32'd1);
    mon_en = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    check("async_rst_pwm", 32'(PwmOut), 32'd0);
    check("async_rst_state", 32'(State), 32'd0);
    check("async_rst_mod", 32'({Failsafe, ModInfo}), 32'h21);

    check("frames_left", 32'(fq.size()), 32'd0);
    check("acks_left", 32'(aq.size()), 32'd0);
    check("pulses_left", 32'(pq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/motor_pulse_scheduler.md
Name: motor_pulse_scheduler

Overview:
- Frame-level controller for the motor pulse modulation block.
- Generates the 50 Hz servo frame timing and drives the 0..23 modulation `State` sequence.
- Arbitrates motor commands (`ModInfo`) from the navigation FSM and a manual/override source, and applies them only at frame boundaries.
- Converts the returned `Pulse` width into the `PwmOut` servo/ESC signal, and forces neutral on command timeout.

Parameters:
- `CLK_RATE`, 100000000, clock frequency in Hz.
- `FRAME_HZ`, 50, servo frame rate. `FRAME_TICKS = CLK_RATE/FRAME_HZ` (2,000,000 clocks).
- `NUM_STATES`, 24, modulation sequence length; `State` wraps at `NUM_STATES-1`.
- `MAX_PULSE`, 250000, clamp on pulse width in clocks (2.5 ms).
- `TIMEOUT_FRAMES`, 25, consecutive frames with no applied command before failsafe.
- `OVR_HOLD_FRAMES`, 50, frames override keeps ownership after its last accepted command.

Ports:
- `CLK` in 1: system clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `NavReq` in 1, `NavModInfo` in 5: navigation command request. `[4:2]` = power level, `[1:0]` = direction.
- `NavAck` out 1: one-cycle accept strobe for the navigation request.
- `OvrReq` in 1, `OvrModInfo` in 5: override command request.
- `OvrAck` out 1: one-cycle accept strobe for the override request.
- `ModInfo` out 5: applied command, to the modulation block.
- `State` out 5: modulation sequence index 0..23, to the modulation block.
- `Pulse` in 21: pulse width in clocks, registered by the modulation block one cycle after `ModInfo`/`State` change.
- `PwmOut` out 1: servo pulse output.
- `FrameStart` out 1: one-cycle strobe when `FrameCnt` = 0.
- `Failsafe` out 1: high while in the `FAILSAFE` state.

Behaviour:
- Clock and reset: single clock `CLK`. Reset is asynchronous, active-low on `RST_N`.
- Reset values:
  - `ModInfo` = 5'b00001 (neutral), `State` = 0, `FrameCnt` = 0.
  - `PwmOut`, `NavAck`, `OvrAck`, `FrameStart` = 0.
  - FSM = `FAILSAFE`, `Failsafe` = 1; pending valid = 0; `PulseLat` = 0.
- Reset mid-frame aborts the frame immediately; `PwmOut` drops asynchronously.
- Frame counter:
  - `FrameCnt` counts 0..`FRAME_TICKS-1`, then wraps. The wrap cycle is the "boundary".
  - On the boundary, `State` increments (`NUM_STATES-1` → 0) and the pending command is applied.
- Pulse capture:
  - `PulseLat` <= min(`Pulse`, `MAX_PULSE`) at `FrameCnt` = 2.
  - `PwmOut` is registered and high when 3 <= `FrameCnt` < 3+`PulseLat`.
  - `PulseLat` = 0 gives no pulse that frame.
- Handshake:
  - A requester holds Req with stable data until its Ack.
  - Ack is asserted the cycle after acceptance, for one cycle. Req is ignored during its Ack cycle.
  - Override has priority on a same-cycle request; `NavReq` is then not acked and stays pending.
- Accepted data is written to the pending register (last accepted wins).
- Direction 2'b11 is illegal and is rewritten to 2'b01 on accept.
- Accept in the boundary cycle bypasses the pending register and is applied at that same boundary.
- FSM states:
  - `NAV`: both sources accepted. Override accept → `OVERRIDE`, hold counter = `OVR_HOLD_FRAMES`.
  - `OVERRIDE`: `NavReq` not acked (stalls). Override accept reloads hold. Hold decrements per boundary; reaching 0 → `NAV`.
  - `FAILSAFE`: `ModInfo` forced to 5'b00001 at each boundary and pending is cleared. First accept → `NAV` or `OVERRIDE` per source; that command is applied at the next boundary.
- Timeout counter:
  - Cleared when a command is applied at a boundary; incremented on boundaries with nothing pending.
  - Reaching `TIMEOUT_FRAMES` from `NAV`/`OVERRIDE` → `FAILSAFE`, with `ModInfo` = 5'b00001 at that boundary.
  - Timeout takes priority over hold expiry in the same frame.

Optional Feature:
- Macro `MOTOR_REVERSE_GUARD_EN`.
- Defined: if the command being applied flips direction 00↔10 relative to current `ModInfo[1:0]`:
  - Apply 5'b00001 for exactly one frame.
  - Apply the new command at the following boundary, unless replaced in the meantime.
- Undefined: commands are applied directly at the boundary.

Test Plan:
- Bench parameters: `CLK_RATE` = 100000, `FRAME_HZ` = 50 (`FRAME_TICKS` = 2000), `TIMEOUT_FRAMES` = 4, `OVR_HOLD_FRAMES` = 3.
- Reset release, no requests → `Failsafe` = 1, `ModInfo` = 5'b00001, `FrameStart` every 2000 clocks, `State` 0,1,..,23,0.
- `NavReq` with `NavModInfo` = 5'b01000 at `FrameCnt` = 500 → `NavAck` at 501; `ModInfo` = 5'b01000 after wrap; `Pulse` = 100 → `PwmOut` high `FrameCnt` 3..102.
- `NavReq` and `OvrReq` same cycle (5'b00000 / 5'b00010) → `OvrAck` only; `ModInfo` = 5'b00010; `NavAck` withheld 3 frames after the last override accept, then given.
- No requests for 4 frames after applying 5'b00000 → `Failsafe` = 1 and `ModInfo` = 5'b00001 at 4th boundary.
- `Pulse` = 300000, and separately `NavModInfo` = 5'b00011 → `PwmOut` width 250000 clocks; `ModInfo` = 5'b00001.
- With `MOTOR_REVERSE_GUARD_EN`, apply 5'b00000 then 5'b00010 → one frame of 5'b00001 between them. Without the macro → direct change.
